mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester and the data (load/store) requester of the 5-stage MIPS pipeline.
- Grants one transaction at a time. Data has priority, with an anti-starvation streak limit for fetch.
- Registers the memory request, returns registered read data, and generates per-requester stall signals for the pipeline.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced. 0 means strict data priority.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch byte address (word aligned)
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
stall_if  out  1  fetch stage must hold
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store, 0 = load
d_byte  in  1  byte-sized access
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data
d_rdata  out  32  load data
d_valid  out  1  one-cycle data completion pulse
stall_mem  out  1  memory stage must hold
mem_req  out  1  request to memory, held until mem_ack
mem_we  out  1  write enable
mem_byte  out  1  byte access
mem_addr  out  ADDR_W  address
mem_wdata  out  32  write data
mem_ack  in  1  memory done; mem_rdata valid this cycle
mem_rdata  in  32  read data

Behaviour:
- Clock/reset: one clock clk; rst synchronous, active-high.
- Reset values:
  - FSM = IDLE; data_streak = 0.
  - mem_req, mem_we, mem_byte, if_valid, d_valid = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE grant decision, evaluated each cycle:
  - d_req only: grant data.
  - if_req only: grant fetch.
  - Both: grant fetch if data_streak == MAX_DATA_STREAK and MAX_DATA_STREAK != 0; otherwise grant data.
  - Neither: stay in IDLE.
- On a grant:
  - Next state is BUSY_D or BUSY_I.
  - mem_req <= 1.
  - mem_addr, mem_we, mem_byte and mem_wdata are latched from the granted requester.
  - For a fetch: mem_we = 0, mem_byte = 0, mem_wdata = 0.
- BUSY_x:
  - mem_* outputs hold stable until mem_ack is sampled high.
  - On mem_ack: mem_req <= 0; mem_rdata is latched into if_rdata (BUSY_I) or d_rdata (BUSY_D); the matching valid <= 1; next state is RESP.
  - For stores, d_rdata still latches mem_rdata; its value is don't-care.
- RESP:
  - The valid pulse is high for exactly this cycle. No grant is made here, so the requester can drop or change its request.
  - Next state is IDLE.
  - if_rdata and d_rdata hold until their next completion.
- Latency: request seen in IDLE at cycle 0 → mem_req from cycle 1 → ack at cycle k ≥ 1 → valid at cycle k+1. Minimum is 2 cycles.
- data_streak (saturating at MAX_DATA_STREAK):
  - Increments on a data grant while if_req = 1.
  - Cleared on any fetch grant, and on a data grant while if_req = 0.
- Stalls (combinational):
  - stall_if = if_req & ~if_valid.
  - stall_mem = d_req & ~d_valid.
- Boundary conditions:
  - mem_ack in IDLE or RESP: ignored; no valid is generated.
  - A request dropped mid-transaction is protocol illegal; the transaction still completes and pulses valid.
  - mem_ack in the same cycle mem_req first rises is legal.
  - A new request arriving in RESP waits for IDLE.
  - rst mid-transaction: mem_req drops the next edge, the in-flight transaction is abandoned, and no valid is generated.
  - Requester address/data inputs are sampled only at grant; changes afterwards are ignored.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0040_0000; memory acks 2 cycles after mem_req with 0x2408_0005 → mem_addr = 0x0040_0000, mem_we = 0; if_valid pulses 1 cycle with if_rdata = 0x2408_0005; stall_if high until then.
- Store then load: d_req, d_we = 1, d_byte = 1, d_addr = 0x1000_0003, d_wdata = 0xAB; then a load from 0x1000_0000 returning 0x0000_00AB → mem_byte = 1 on the store, mem_we = 0 on the load, d_rdata = 0x0000_00AB.
- Simultaneous requests, MAX_DATA_STREAK = 4: if_req held and d_req re-asserted each IDLE → grants D, D, D, D, I; data_streak returns to 0 after the fetch grant.
- MAX_DATA_STREAK = 0 with both requests continuously pending → only data is granted; stall_if stays high.
- Spurious mem_ack = 1 in IDLE with no requests → no valid pulse, mem_req stays 0, state stays IDLE.
- rst asserted one cycle into BUSY_D with no ack yet → next cycle mem_req = 0, d_valid = 0, state IDLE; a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port of the 5-stage MIPS pipeline.
// Instruction fetch and data (load/store) requesters share one port. Only one
// transaction is in flight at a time. Data wins ties, but after
// MAX_DATA_STREAK consecutive data grants with a fetch waiting, the fetch is
// forced through. MAX_DATA_STREAK = 0 gives strict data priority.
//
// Handshake: a requester raises *_req with its address/data and holds it until
// its one-cycle *_valid pulse; the arbiter samples address/data only at grant.
// Toward memory, mem_req and the mem_* fields stay stable from grant until
// mem_ack is sampled high (mem_ack may coincide with the first mem_req cycle);
// mem_rdata is taken in that same cycle.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [7:0]        dbg_streak
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [7:0] STREAK_MAX = 8'(MAX_DATA_STREAK);

  state_t     state_q, state_d;
  logic [7:0] streak_q, streak_d;
  logic       grant_i, grant_d;

  // Grant decision, next state and next streak count.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && if_req) begin
          if (MAX_DATA_STREAK != 0 && streak_q == STREAK_MAX) grant_i = 1'b1;
          else                                                grant_d = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_i = 1'b1;
        end
        if (grant_i) begin
          state_d  = BUSY_I;
          streak_d = 8'd0;
        end else if (grant_d) begin
          state_d = BUSY_D;
          // Streak only counts data grants that made a fetch wait.
          if (!if_req)                     streak_d = 8'd0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 8'd1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        // Valid pulse cycle; requesters may drop or change requests here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, memory request latching and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_byte  <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'd0;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_byte  <= d_byte;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
      // Acks outside BUSY_x are ignored; store completions also load d_rdata.
      if (state_q == BUSY_I && mem_ack) begin
        mem_req  <= 1'b0;
        if_rdata <= mem_rdata;
        if_valid <= 1'b1;
      end
      if (state_q == BUSY_D && mem_ack) begin
        mem_req <= 1'b0;
        d_rdata <= mem_rdata;
        d_valid <= 1'b1;
      end
    end
  end

  assign stall_if   = if_req & ~if_valid;
  assign stall_mem  = d_req & ~d_valid;
  assign dbg_state  = state_q;
  assign dbg_streak = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with streak limit 4 and one
// with strict data priority. Expected addresses, requester kind and read data
// are queued when a request is driven and consumed as transactions complete.
module tb_mem_port_arbiter;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  bit          kind_q[$];

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared requester inputs
  logic        if_req, d_req, d_we, d_byte, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, stall_if, d_valid, stall_mem, mem_req, mem_we, mem_byte;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_streak;

  // strict-priority instance
  logic        b_if_req, b_d_req, b_mem_ack;
  logic [31:0] b_mem_rdata;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_valid, b_stall_if, b_d_valid, b_stall_mem, b_mem_req, b_mem_we, b_mem_byte;
  logic [1:0]  b_dbg_state;
  logic [7:0]  b_dbg_streak;

  mem_port_arbiter #(.MAX_DATA_STREAK(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  mem_port_arbiter #(.MAX_DATA_STREAK(0), .ADDR_W(32)) dut_strict (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid), .stall_if(b_stall_if),
    .d_req(b_d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid), .stall_mem(b_stall_mem),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_byte(b_mem_byte), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .dbg_state(b_dbg_state), .dbg_streak(b_dbg_streak)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // wait for a grant on the main instance, then answer it after `delay` cycles
  task automatic serve(input int delay, input logic [31:0] rdata, input logic exp_we,
                       input logic exp_byte, input logic [31:0] exp_wdata, input bit perturb);
    int n;
    logic [31:0] ea, er;
    bit fetch;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("grant_seen", {31'd0, mem_req}, 32'd1);
    ea = addr_q.pop_front();
    fetch = kind_q.pop_front();
    er = exp_q.pop_front();
    check("grant_addr", mem_addr, ea);
    check("grant_we", {31'd0, mem_we}, {31'd0, exp_we});
    check("grant_byte", {31'd0, mem_byte}, {31'd0, exp_byte});
    check("grant_wdata", mem_wdata, exp_wdata);
    check("busy_state", {30'd0, dbg_state}, fetch ? {30'd0, S_BUSY_I} : {30'd0, S_BUSY_D});
    if (perturb) begin
      if_addr = ~if_addr;
      d_addr  = ~d_addr;
      d_wdata = ~d_wdata;
    end
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_req", {31'd0, mem_req}, 32'd1);
      check("hold_addr", mem_addr, ea);
      check("hold_wdata", mem_wdata, exp_wdata);
      check("hold_stall", {31'd0, fetch ? stall_if : stall_mem}, 32'd1);
      check("hold_no_valid", {30'd0, if_valid, d_valid}, 32'd0);
    end
    mem_rdata = rdata;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    check("ack_drop_req", {31'd0, mem_req}, 32'd0);
    check("valid_if", {31'd0, if_valid}, {31'd0, fetch});
    check("valid_d", {31'd0, d_valid}, {31'd0, !fetch});
    check("rdata", fetch ? if_rdata : d_rdata, er);
    check("resp_state", {30'd0, dbg_state}, {30'd0, S_RESP});
    check("stall_release", {31'd0, fetch ? stall_if : stall_mem}, 32'd0);
    tick();
    check("pulse_end", {30'd0, if_valid, d_valid}, 32'd0);
    check("back_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("rdata_hold", fetch ? if_rdata : d_rdata, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [7:0] streak_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};

  initial begin
    int n;
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; d_byte = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    b_if_req = 0; b_d_req = 0; b_mem_ack = 0; b_mem_rdata = 0;
    tick();
    tick();

    // reset values
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {30'd0, mem_we, mem_byte}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    check("rst_valid", {30'd0, if_valid, d_valid}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("rst_streak", {24'd0, dbg_streak}, 32'd0);
    rst = 1'b0;
    tick();

    // single fetch, ack two cycles after mem_req, inputs disturbed after grant
    if_req = 1; if_addr = 32'h0040_0000;
    addr_q.push_back(32'h0040_0000); kind_q.push_back(1'b1); exp_q.push_back(32'h2408_0005);
    #1;
    check("stall_if_pending", {31'd0, stall_if}, 32'd1);
    serve(2, 32'h2408_0005, 1'b0, 1'b0, 32'd0, 1'b1);
    if_req = 0;
    tick();

    // byte store then word load
    d_req = 1; d_we = 1; d_byte = 1; d_addr = 32'h1000_0003; d_wdata = 32'h0000_00AB;
    addr_q.push_back(32'h1000_0003); kind_q.push_back(1'b0); exp_q.push_back(32'h0000_0000);
    serve(1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_00AB, 1'b0);
    d_we = 0; d_byte = 0; d_addr = 32'h1000_0000; d_wdata = 32'd0;
    addr_q.push_back(32'h1000_0000); kind_q.push_back(1'b0); exp_q.push_back(32'h0000_00AB);
    serve(0, 32'h0000_00AB, 1'b0, 1'b0, 32'd0, 1'b0);
    d_req = 0;
    check("streak_after_solo_data", {24'd0, dbg_streak}, 32'd0);
    tick();

    // both requesting: D, D, D, D, then forced I
    if_req = 1; if_addr = 32'h0040_0100;
    d_req = 1; d_addr = 32'h1000_0100; d_wdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      addr_q.push_back(i < 4 ? 32'h1000_0100 : 32'h0040_0100);
      kind_q.push_back(i == 4);
      exp_q.push_back(32'h0000_1000 + i);
    end
    for (int i = 0; i < 5; i++) begin
      serve(0, 32'h0000_1000 + i, 1'b0, 1'b0, 32'd0, 1'b0);
      check("streak_count", {24'd0, dbg_streak}, {24'd0, streak_exp[i]});
    end
    if_req = 0; d_req = 0;
    tick();

    // spurious ack in IDLE
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spurious_req", {31'd0, mem_req}, 32'd0);
      check("spurious_valid", {30'd0, if_valid, d_valid}, 32'd0);
      check("spurious_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    end
    mem_ack = 0;
    tick();

    // reset one cycle into BUSY_D
    d_req = 1; d_we = 0; d_addr = 32'h1000_0040;
    tick();
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    check("pre_rst_state", {30'd0, dbg_state}, {30'd0, S_BUSY_D});
    tick();
    rst = 1; d_req = 0;
    tick();
    rst = 0;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, d_valid}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("mid_rst_rdata", d_rdata, 32'd0);
    tick();
    check("post_rst_valid", {31'd0, d_valid}, 32'd0);
    if_req = 1; if_addr = 32'h0040_0004;
    addr_q.push_back(32'h0040_0004); kind_q.push_back(1'b1); exp_q.push_back(32'h8C09_0000);
    serve(1, 32'h8C09_0000, 1'b0, 1'b0, 32'd0, 1'b0);
    if_req = 0;
    tick();

    // strict data priority instance, both requests held
    d_addr = 32'h1000_0200; d_wdata = 32'd0; d_we = 0; d_byte = 0;
    b_if_req = 1; b_d_req = 1;
    for (int i = 0; i < 6; i++) begin
      addr_q.push_back(32'h1000_0200);
      exp_q.push_back(32'h0000_5000 + i);
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ea, er;
      ea = addr_q.pop_front();
      er = exp_q.pop_front();
      n = 0;
      while (b_mem_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check("strict_grant_seen", {31'd0, b_mem_req}, 32'd1);
      check("strict_grant_addr", b_mem_addr, ea);
      check("strict_state", {30'd0, b_dbg_state}, {30'd0, S_BUSY_D});
      b_mem_rdata = 32'h0000_5000 + i;
      b_mem_ack = 1;
      tick();
      b_mem_ack = 0;
      check("strict_d_valid", {31'd0, b_d_valid}, 32'd1);
      check("strict_if_valid", {31'd0, b_if_valid}, 32'd0);
      check("strict_stall_if", {31'd0, b_stall_if}, 32'd1);
      check("strict_rdata", b_d_rdata, er);
      tick();
    end
    b_if_req = 0; b_d_req = 0;
    check("strict_streak", {24'd0, b_dbg_streak}, 32'd0);
    tick();

    check("queues_drained", addr_q.size() + exp_q.size() + kind_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
